// File: rtl/simplez_loader.sv
// Serial program loader for the Simplez core: parses SYNC/LEN/data/CHK byte
// frames, writes 12-bit words into program RAM and gates the CPU reset.
module simplez_loader #(
    parameter int AW      = 9,
    parameter int DW      = 12,
    parameter int TIMEOUT = 1_200_000
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    output logic          mem_we,
    output logic          cpu_rstn,
    output logic          busy,
    output logic          done,
    output logic          err
);
    localparam int TW  = $clog2(TIMEOUT + 1);
    localparam int WCW = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_H, S_LEN_L, S_DATA_H, S_DATA_L, S_CHK
    } state_t;

    state_t         state_q, state_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [WCW-1:0] wcnt_q, wcnt_d;
    logic [7:0]     sum_q, sum_d;
    logic [DW-9:0]  hi_q, hi_d;
    logic [7:0]     lenh_q, lenh_d;
    logic [TW-1:0]  tmr_q, tmr_d;
    logic [DW-1:0]  din_q, din_d;
    logic           we_q, we_d;
    logic           done_q, done_d;
    logic           err_q, err_d;
    logic           cpu_rstn_q, cpu_rstn_d;
    logic [15:0]    len16;

    assign len16 = {lenh_q, rx_data};

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wcnt_d     = wcnt_q;
        sum_d      = sum_q;
        hi_d       = hi_q;
        lenh_d     = lenh_q;
        din_d      = din_q;
        we_d       = 1'b0;
        done_d     = done_q;
        err_d      = err_q;
        cpu_rstn_d = cpu_rstn_q;

        // Address moves only once the write strobe has been presented.
        if (we_q)
            addr_d = addr_q + 1'b1;
        // done rises first; the CPU is released one cycle later.
        if (done_q)
            cpu_rstn_d = 1'b1;

        if (state_q == S_IDLE || rx_valid)
            tmr_d = '0;
        else
            tmr_d = tmr_q + 1'b1;

        if (rx_valid) begin
            unique case (state_q)
                S_IDLE: begin
                    if (rx_data == 8'h5A) begin
                        state_d    = S_LEN_H;
                        done_d     = 1'b0;
                        err_d      = 1'b0;
                        cpu_rstn_d = 1'b0;
                        sum_d      = '0;
                        addr_d     = '0;
                    end
                end
                S_LEN_H: begin
                    lenh_d  = rx_data;
                    state_d = S_LEN_L;
                end
                S_LEN_L: begin
                    if ({1'b0, len16} >= 17'(1 << AW)) begin
                        state_d = S_IDLE;
                        err_d   = 1'b1;
                    end else begin
                        wcnt_d  = len16[WCW-1:0] + 1'b1;
                        state_d = S_DATA_H;
                    end
                end
                S_DATA_H: begin
                    hi_d    = rx_data[DW-9:0];
                    sum_d   = sum_q + rx_data;
                    state_d = S_DATA_L;
                end
                S_DATA_L: begin
                    sum_d   = sum_q + rx_data;
                    we_d    = 1'b1;
                    din_d   = {hi_q, rx_data};
                    wcnt_d  = wcnt_q - 1'b1;
                    state_d = (wcnt_q == WCW'(1)) ? S_CHK : S_DATA_H;
                end
                S_CHK: begin
                    if (rx_data == sum_q)
                        done_d = 1'b1;
                    else
                        err_d = 1'b1;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end else if (state_q != S_IDLE && tmr_q == TW'(TIMEOUT - 1)) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            wcnt_q     <= '0;
            sum_q      <= '0;
            hi_q       <= '0;
            lenh_q     <= '0;
            tmr_q      <= '0;
            din_q      <= '0;
            we_q       <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            cpu_rstn_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wcnt_q     <= wcnt_d;
            sum_q      <= sum_d;
            hi_q       <= hi_d;
            lenh_q     <= lenh_d;
            tmr_q      <= tmr_d;
            din_q      <= din_d;
            we_q       <= we_d;
            done_q     <= done_d;
            err_q      <= err_d;
            cpu_rstn_q <= cpu_rstn_d;
        end
    end

    assign mem_addr = addr_q;
    assign mem_din  = din_q;
    assign mem_we   = we_q;
    assign cpu_rstn = cpu_rstn_q;
    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign err      = err_q;
endmodule

// File: tb/tb_simplez_loader.sv
// Directed-frame bench for simplez_loader; RAM writes go through a
// scoreboard queue checked by a monitor, status flags are checked inline.
module tb_simplez_loader;
    localparam int AW = 9;
    localparam int DW = 12;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          rstn;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic          mem_we;
    logic          cpu_rstn, busy, done, err;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t        sb[$];
    logic [7:0] fb[$];
    int         checks = 0;
    int         failures = 0;
    int         wr_cnt = 0;
    int         wr_snap;
    logic [AW-1:0] last_addr = '0;
    logic [7:0] csum;

    simplez_loader #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rstn(rstn), .rx_data(rx_data), .rx_valid(rx_valid),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we),
        .cpu_rstn(cpu_rstn), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        wr_t e;
        forever begin
            @(negedge clk);
            if (rstn && mem_we) begin
                wr_cnt++;
                last_addr = mem_addr;
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_write: got addr=%0h data=%0h expected no write",
                             mem_addr, mem_din);
                end else begin
                    e = sb.pop_front();
                    if (mem_addr !== e.addr || mem_din !== e.data) begin
                        failures++;
                        $display("FAIL write: got addr=%0h data=%0h expected addr=%0h data=%0h",
                                 mem_addr, mem_din, e.addr, e.data);
                    end
                end
            end
        end
    endtask

    task automatic push_wr(input int a, input int d);
        wr_t e;
        e.addr = AW'(a);
        e.data = DW'(d);
        sb.push_back(e);
    endtask

    // Called at a negedge; returns at the negedge after the byte was sampled.
    task automatic send(input logic [7:0] b, input int gap);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_fb(input int gap);
        foreach (fb[i]) send(fb[i], gap);
        fb.delete();
    endtask

    initial begin
        fork
            monitor();
        join_none
        rstn = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_din", mem_din, 0);
        chk("rst_cpu_rstn", cpu_rstn, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        rstn = 1'b1;
        @(negedge clk);

        // Good frame, with SYNC/CHK timing of cpu_rstn
        push_wr(0, 'hA05); push_wr(1, 'h3FF);
        send(8'h5A, 0);
        chk("sync_cpu_rstn", cpu_rstn, 0);
        chk("sync_busy", busy, 1);
        fb = '{8'h00, 8'h01, 8'h0A, 8'h05, 8'h03, 8'hFF, 8'h11};
        send_fb(0);
        chk("good_done", done, 1);
        chk("good_err", err, 0);
        chk("good_cpu_rstn_t1", cpu_rstn, 0);
        chk("good_busy", busy, 0);
        @(negedge clk);
        chk("good_cpu_rstn_t2", cpu_rstn, 1);
        chk("good_sb_empty", sb.size(), 0);

        // Bad checksum, then resend
        push_wr(0, 'hA05); push_wr(1, 'h3FF);
        fb = '{8'h5A, 8'h00, 8'h01, 8'h0A, 8'h05, 8'h03, 8'hFF, 8'h12};
        send_fb(1);
        chk("bad_err", err, 1);
        chk("bad_done", done, 0);
        repeat (3) @(negedge clk);
        chk("bad_cpu_rstn", cpu_rstn, 0);
        push_wr(0, 'hA05); push_wr(1, 'h3FF);
        fb = '{8'h5A, 8'h00, 8'h01, 8'h0A, 8'h05, 8'h03, 8'hFF, 8'h11};
        send_fb(2);
        chk("resend_done", done, 1);
        chk("resend_err", err, 0);
        chk("resend_cpu_rstn", cpu_rstn, 1);

        // 0x5A as data, unused HI bits ignored, back-to-back bytes
        push_wr(0, 'h15A); push_wr(1, 'hA5A);
        fb = '{8'h5A, 8'h00, 8'h01, 8'hF1, 8'h5A, 8'h5A, 8'h5A, 8'hFF};
        send_fb(0);
        chk("data5a_done", done, 1);
        chk("data5a_err", err, 0);

        // Full-size frame, N = 512
        fb = '{8'h5A, 8'h01, 8'hFF};
        csum = 8'h00;
        for (int i = 0; i < 512; i++) begin
            logic [15:0] w;
            w = 16'(i);
            fb.push_back(w[15:8]);
            fb.push_back(w[7:0]);
            csum = csum + w[15:8] + w[7:0];
            push_wr(i, i);
        end
        fb.push_back(csum);
        send_fb(0);
        chk("n512_done", done, 1);
        chk("n512_last_addr", last_addr, 'h1FF);
        chk("n512_sb_empty", sb.size(), 0);

        // Oversize length aborts right after LEN_L
        wr_snap = wr_cnt;
        fb = '{8'h5A, 8'h02, 8'h00};
        send_fb(0);
        chk("len_err", err, 1);
        chk("len_busy", busy, 0);
        chk("len_done", done, 0);
        repeat (4) @(negedge clk);
        chk("len_no_write", wr_cnt, wr_snap);

        // Inter-byte timeout
        fb = '{8'h5A, 8'h00, 8'h00, 8'h0A};
        send_fb(0);
        repeat (TO / 2) @(negedge clk);
        chk("to_busy_before", busy, 1);
        chk("to_err_before", err, 0);
        repeat (TO) @(negedge clk);
        chk("to_err", err, 1);
        chk("to_busy", busy, 0);
        chk("to_cpu_rstn", cpu_rstn, 0);
        chk("to_no_write", wr_cnt, wr_snap);

        // Garbage in IDLE
        fb = '{8'h00, 8'hFF, 8'h33};
        send_fb(1);
        chk("garb_busy", busy, 0);
        chk("garb_err", err, 1);
        chk("garb_done", done, 0);

        // Reset mid-frame after the first write
        push_wr(0, 'hA05);
        fb = '{8'h5A, 8'h00, 8'h01, 8'h0A, 8'h05};
        send_fb(0);
        @(negedge clk);
        chk("mid_sb_empty", sb.size(), 0);
        rstn = 1'b0;
        #1;
        chk("mid_rst_we", mem_we, 0);
        chk("mid_rst_addr", mem_addr, 0);
        chk("mid_rst_din", mem_din, 0);
        chk("mid_rst_cpu_rstn", cpu_rstn, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_err", err, 0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        push_wr(0, 'hA05); push_wr(1, 'h3FF);
        fb = '{8'h5A, 8'h00, 8'h01, 8'h0A, 8'h05, 8'h03, 8'hFF, 8'h11};
        send_fb(0);
        chk("post_rst_done", done, 1);
        @(negedge clk);
        chk("post_rst_cpu_rstn", cpu_rstn, 1);
        chk("post_rst_sb_empty", sb.size(), 0);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
